// File: rtl/mul8_seq.sv
// ============================================================================
// Module      : mul8_seq
// Description : Iterative 8x8 -> 16-bit multiplier sharing one 4x4 array
//               multiplier (mul_lrtl) over four cycles, valid/ready on both
//               sides. Optional macro MUL8_SEQ_SIGNED_EN selects two's-
//               complement operands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_lrtl (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [7:0] row [4];

    generate
        for (genvar i = 0; i < 4; i++) begin : g_row
            assign row[i] = b[i] ? ({4'd0, a} << i) : 8'd0;
        end
    endgenerate

    assign p = row[0] + row[1] + row[2] + row[3];
endmodule

module mul8_seq #(
    parameter int unsigned TAG_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_p,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [1:0]       step_q, step_d;
    logic [7:0]       a_q, a_d;
    logic [7:0]       b_q, b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [15:0]      acc_q, acc_d;
    logic [15:0]      out_p_q, out_p_d;

    logic [3:0]       nib_a, nib_b;
    logic [7:0]       pp;
    logic [15:0]      pp_sh;
    logic [15:0]      sum;
    logic [15:0]      result;

`ifdef MUL8_SEQ_SIGNED_EN
    logic             neg_q, neg_d;
`endif

    // Operands to the shared array come only from latched state.
    assign nib_a = step_q[1] ? a_q[7:4] : a_q[3:0];
    assign nib_b = step_q[0] ? b_q[7:4] : b_q[3:0];

    mul_lrtl u_mul (
        .a (nib_a),
        .b (nib_b),
        .p (pp)
    );

    always_comb begin
        pp_sh = {8'd0, pp};
        case (step_q)
            2'd0:    pp_sh = {8'd0, pp};
            2'd3:    pp_sh = {pp, 8'd0};
            default: pp_sh = {4'd0, pp, 4'd0};
        endcase
    end

    assign sum = acc_q + pp_sh;

`ifdef MUL8_SEQ_SIGNED_EN
    assign result = neg_q ? (16'd0 - sum) : sum;
`else
    assign result = sum;
`endif

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        tag_d   = tag_q;
        acc_d   = acc_q;
        out_p_d = out_p_q;
`ifdef MUL8_SEQ_SIGNED_EN
        neg_d   = neg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
`ifdef MUL8_SEQ_SIGNED_EN
                    // Magnitudes: -128 maps to 0x80, which reads as 128 unsigned.
                    a_d   = in_a[7] ? (8'd0 - in_a) : in_a;
                    b_d   = in_b[7] ? (8'd0 - in_b) : in_b;
                    neg_d = in_a[7] ^ in_b[7];
`else
                    a_d   = in_a;
                    b_d   = in_b;
`endif
                    tag_d   = in_tag;
                    acc_d   = 16'd0;
                    step_d  = 2'd0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                acc_d = sum;
                if (step_q == 2'd3) begin
                    out_p_d = result;
                    state_d = S_DONE;
                end else begin
                    step_d = step_q + 2'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= 2'd0;
            a_q     <= 8'd0;
            b_q     <= 8'd0;
            tag_q   <= '0;
            acc_q   <= 16'd0;
            out_p_q <= 16'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
            acc_q   <= acc_d;
            out_p_q <= out_p_d;
        end
    end

`ifdef MUL8_SEQ_SIGNED_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end
`endif

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_MUL);
    assign out_valid = (state_q == S_DONE);
    assign out_p     = out_p_q;
    // The tag latch only moves at acceptance, so it doubles as out_tag.
    assign out_tag   = tag_q;
endmodule

`default_nettype wire

// File: tb/tb_mul8_seq.sv
// ============================================================================
// Module      : tb_mul8_seq
// Description : Directed and randomized self-checking bench for mul8_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul8_seq;
    localparam int TAG_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_p;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int passed = 0;
    int total  = 0;

    mul8_seq #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int max);
        int n;
        n = 0;
        while (!out_valid && n < max) begin
            cyc();
            n++;
        end
        chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
`ifdef MUL8_SEQ_SIGNED_EN
        logic signed [15:0] sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
`else
        return {8'd0, a} * {8'd0, b};
`endif
    endfunction

    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [TAG_W-1:0] tag, input logic [15:0] exp);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        cyc();
        in_valid = 1'b0;
        wait_out(10);
        chk(name, {16'd0, out_p}, {16'd0, exp});
        chk({name, "_tag"}, {30'd0, out_tag}, {30'd0, tag});
        cyc();
    endtask

    initial begin
        logic [TAG_W+15:0] sb[$];
        logic [TAG_W+15:0] e;
        int done;
        int cycles;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 8'd0;
        in_b      = 8'd0;
        in_tag    = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_p", {16'd0, out_p}, 32'd0);
        chk("rst_out_tag", {30'd0, out_tag}, 32'd0);
        rst = 1'b0;
        cyc();

        // 0xFF*0xFF: exact 4-edge latency, one-cycle result pulse
        in_valid = 1'b1;
        in_a     = 8'hFF;
        in_b     = 8'hFF;
        in_tag   = 2'd2;
        cyc();
        in_valid = 1'b0;
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_in_ready", {31'd0, in_ready}, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk("t1_early_valid", {31'd0, out_valid}, 32'd0);
        end
        cyc();
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
`ifdef MUL8_SEQ_SIGNED_EN
        chk("t1_p", {16'd0, out_p}, 32'h0001);
`else
        chk("t1_p", {16'd0, out_p}, 32'hFE01);
`endif
        chk("t1_tag", {30'd0, out_tag}, 32'd2);
        cyc();
        chk("t1_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("t1_ready_back", {31'd0, in_ready}, 32'd1);

        // Back-to-back with the second request held valid
        in_valid = 1'b1;
        in_a     = 8'h00;
        in_b     = 8'hA5;
        in_tag   = 2'd1;
        cyc();
        in_a   = 8'h12;
        in_b   = 8'h34;
        in_tag = 2'd0;
        wait_out(10);
        chk("t2_p0", {16'd0, out_p}, 32'h0000);
        chk("t2_tag0", {30'd0, out_tag}, 32'd1);
        cyc();
        chk("t2_idle_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        chk("t2_accept_busy", {31'd0, busy}, 32'd1);
        in_valid = 1'b0;
        wait_out(10);
        chk("t2_p1", {16'd0, out_p}, 32'h03A8);
        chk("t2_tag1", {30'd0, out_tag}, 32'd0);
        cyc();

        // Backpressure: out_ready low for three edges after out_valid rises
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 8'h0F;
        in_b      = 8'h11;
        in_tag    = 2'd3;
        cyc();
        in_valid = 1'b0;
        wait_out(10);
        for (int k = 0; k < 4; k++) begin
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_p", {16'd0, out_p}, 32'h00FF);
            chk("bp_tag", {30'd0, out_tag}, 32'd3);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            if (k < 3) cyc();
        end
        out_ready = 1'b1;
        cyc();
        chk("bp_consumed", {31'd0, out_valid}, 32'd0);

        // Reset during MUL step1 aborts the operation
        in_valid = 1'b1;
        in_a     = 8'h10;
        in_b     = 8'h10;
        in_tag   = 2'd1;
        cyc();
        in_valid = 1'b0;
        cyc();
        rst = 1'b1;
        #2;
        chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_out_p", {16'd0, out_p}, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("mrst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        run_op("mrst_after", 8'h03, 8'h05, 2'd2, 16'h000F);

`ifdef MUL8_SEQ_SIGNED_EN
        run_op("v_80_7f", 8'h80, 8'h7F, 2'd0, 16'hC080);
        run_op("v_80_80", 8'h80, 8'h80, 2'd1, 16'h4000);
        run_op("v_ff_01", 8'hFF, 8'h01, 2'd2, 16'hFFFF);
        run_op("v_a5_5a", 8'hA5, 8'h5A, 2'd3, 16'hE002);
`else
        run_op("v_80_7f", 8'h80, 8'h7F, 2'd0, 16'h3F80);
        run_op("v_80_80", 8'h80, 8'h80, 2'd1, 16'h4000);
        run_op("v_ff_01", 8'hFF, 8'h01, 2'd2, 16'h00FF);
        run_op("v_a5_5a", 8'hA5, 8'h5A, 2'd3, 16'h3A02);
`endif

        // Random traffic against an in-order scoreboard
        done   = 0;
        cycles = 0;
        while (done < 1000 && cycles < 30000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            in_tag    = TAG_W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) sb.push_back({in_tag, model(in_a, in_b)});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("rand_spurious", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rand_p", {16'd0, out_p}, {16'd0, e[15:0]});
                    chk("rand_tag", {30'd0, out_tag}, {30'd0, e[TAG_W+15:16]});
                    done++;
                end
            end
            cyc();
            cycles++;
        end
        chk("rand_count", done, 32'd1000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

`default_nettype wire
